// File: rtl/mult_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arb
// Purpose  : Round-robin arbiter/sequencer sharing one free-running Booth
//            multiplier among NREQ requesters. It latches the winner's
//            operands, discards the first (possibly stale) done pulse,
//            returns the next product and times out a stalled multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module mult_share_arb #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_in,
  input  logic [NREQ*WIDTH-1:0]   b_in,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]      rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [WIDTH-1:0]        mult_a,
  output logic [WIDTH-1:0]        mult_b,
  input  logic                    mult_done,
  input  logic [2*WIDTH-1:0]      mult_m
);

  localparam int C_PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int C_TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [C_PW-1:0]     r_ptr, w_ptr_nxt;
  logic [C_PW-1:0]     r_owner, w_owner_nxt;
  logic [C_TW-1:0]     r_tcnt, w_tcnt_nxt;
  logic [NREQ-1:0]     w_gnt_nxt, w_rsp_valid_nxt;
  logic [2*WIDTH-1:0]  w_rsp_data_nxt;
  logic                w_rsp_err_nxt;
  logic [WIDTH-1:0]    w_mult_a_nxt, w_mult_b_nxt;

  logic                w_found;
  logic [C_PW-1:0]     w_win;
  logic [C_PW:0]       w_sum;
  logic [C_PW-1:0]     w_idx;
  logic [C_PW-1:0]     w_owner_inc;
  logic                w_tmo;

  // Winner search: first requesting index at or after ptr, wrapping modulo NREQ
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (C_PW+1)'(k);
      if (w_sum >= (C_PW+1)'(NREQ)) begin
        w_sum = w_sum - (C_PW+1)'(NREQ);
      end
      w_idx = w_sum[C_PW-1:0];
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_owner_inc = (r_owner == C_PW'(NREQ - 1)) ? '0 : r_owner + C_PW'(1);
  assign w_tmo       = (r_tcnt == C_TW'(TIMEOUT - 1));
  assign busy        = (r_state != IDLE);

  // Next-state and next-output decode; the first done after a grant is dropped
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_owner_nxt     = r_owner;
    w_tcnt_nxt      = r_tcnt;
    w_gnt_nxt       = '0;
    w_rsp_valid_nxt = '0;
    w_rsp_data_nxt  = rsp_data;
    w_rsp_err_nxt   = rsp_err;
    w_mult_a_nxt    = mult_a;
    w_mult_b_nxt    = mult_b;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_owner_nxt  = w_win;
          w_gnt_nxt    = NREQ'(1) << w_win;
          w_mult_a_nxt = a_in[w_win*WIDTH +: WIDTH];
          w_mult_b_nxt = b_in[w_win*WIDTH +: WIDTH];
          w_tcnt_nxt   = '0;
          w_state_nxt  = SYNC;
        end
      end
      SYNC: begin
        if (mult_done) begin
          w_tcnt_nxt  = '0;
          w_state_nxt = RUN;
        end else if (w_tmo) begin
          w_rsp_valid_nxt = NREQ'(1) << r_owner;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_data_nxt  = '0;
          w_ptr_nxt       = w_owner_inc;
          w_state_nxt     = IDLE;
        end else begin
          w_tcnt_nxt = r_tcnt + C_TW'(1);
        end
      end
      RUN: begin
        if (mult_done) begin
          w_rsp_valid_nxt = NREQ'(1) << r_owner;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_data_nxt  = mult_m;
          w_ptr_nxt       = w_owner_inc;
          w_state_nxt     = IDLE;
        end else if (w_tmo) begin
          w_rsp_valid_nxt = NREQ'(1) << r_owner;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_data_nxt  = '0;
          w_ptr_nxt       = w_owner_inc;
          w_state_nxt     = IDLE;
        end else begin
          w_tcnt_nxt = r_tcnt + C_TW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_owner   <= '0;
      r_tcnt    <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      mult_a    <= '0;
      mult_b    <= '0;
    end else begin
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_tcnt    <= w_tcnt_nxt;
      gnt       <= w_gnt_nxt;
      rsp_valid <= w_rsp_valid_nxt;
      rsp_data  <= w_rsp_data_nxt;
      rsp_err   <= w_rsp_err_nxt;
      mult_a    <= w_mult_a_nxt;
      mult_b    <= w_mult_b_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_arb
// Purpose  : Directed self-checking bench for mult_share_arb with a
//            behavioural multiplier stub (normal / stale-pulse / dead modes)
//            and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_share_arb;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 32;
  localparam int PER     = WIDTH + 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in, b_in;
  logic [NREQ-1:0]       gnt, rsp_valid;
  logic [2*WIDTH-1:0]    rsp_data;
  logic                  rsp_err, busy;
  logic [WIDTH-1:0]      mult_a, mult_b;
  logic                  mult_done;
  logic [2*WIDTH-1:0]    mult_m;

  always #5 clk = ~clk;

  mult_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .mult_a(mult_a), .mult_b(mult_b),
    .mult_done(mult_done), .mult_m(mult_m)
  );

  typedef struct packed {
    logic [NREQ-1:0]    who;
    logic [2*WIDTH-1:0] data;
    logic               err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_rsp_cyc = -1;
  int   n_rsp = 0;
  int   mode = 0;          // 0 normal, 1 stale pulse, 2 dead
  int   since = 0;
  int   mc;
  logic md_d;
  logic [7:0] la, lb;

  function automatic logic [15:0] prod(input logic [7:0] x, input logic [7:0] y);
    logic signed [15:0] sx, sy, r;
    sx = {{8{x[7]}}, x};
    sy = {{8{y[7]}}, y};
    r  = sx * sy;
    return r;
  endfunction

  // Free-running multiplier model: samples operands the cycle after each done
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc <= 0; md_d <= 1'b0; la <= '0; lb <= '0;
    end else begin
      mc   <= (mc == PER - 1) ? 0 : mc + 1;
      md_d <= (mc == PER - 1);
      if (md_d) begin
        la <= mult_a;
        lb <= mult_b;
      end
    end
  end

  // Cycles since the last grant, used by the stale-pulse stub
  always @(posedge clk) since <= (gnt != 0) ? 1 : since + 1;

  // Multiplier pin mux per stub mode
  always_comb begin
    mult_done = 1'b0;
    mult_m    = '0;
    case (mode)
      0: begin
        mult_done = (mc == PER - 1);
        mult_m    = prod(la, lb);
      end
      1: begin
        if (gnt != 0) begin
          mult_done = 1'b1;
          mult_m    = 16'hDEAD;
        end else if (since == 3) begin
          mult_done = 1'b1;
          mult_m    = prod(mult_a, mult_b);
        end
      end
      default: ;
    endcase
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Response monitor / scoreboard pop
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt != 0 || rsp_valid != 0)
        check("gnt_rsp_exclusive", {31'b0, (gnt != 0) && (rsp_valid != 0)}, 0);
      if (gnt != 0) check("gnt_onehot", {31'b0, $onehot(gnt)}, 1);
      if (rsp_valid != 0) begin
        n_rsp++;
        last_rsp_cyc = cyc;
        if (sb.size() == 0) begin
          check("rsp_unexpected", {28'b0, rsp_valid}, 0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_who",  {28'b0, rsp_valid}, {28'b0, mon_e.who});
          check("rsp_data", {16'b0, rsp_data},  {16'b0, mon_e.data});
          check("rsp_err",  {31'b0, rsp_err},   {31'b0, mon_e.err});
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic [NREQ-1:0] who, input logic [15:0] data, input logic err);
    exp_t e;
    e.who = who; e.data = data; e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(input logic [NREQ-1:0] exp, input string tag);
    for (int i = 0; i < 40 && gnt == 0; i++) step();
    check(tag, {28'b0, gnt}, {28'b0, exp});
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    check("drain", sb.size(), 0);
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    a_in[i*WIDTH +: WIDTH] = a;
    b_in[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic txn(input int i, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] data, input string tag);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << i;
    set_ops(i, a, b);
    expect_rsp(oh, data, 1'b0);
    req = oh;
    step();
    wait_gnt(oh, tag);
    req = '0;
    drain(40);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_gnt"},   {28'b0, gnt}, 0);
    check({tag, "_rspv"},  {28'b0, rsp_valid}, 0);
    check({tag, "_data"},  {16'b0, rsp_data}, 0);
    check({tag, "_err"},   {31'b0, rsp_err}, 0);
    check({tag, "_busy"},  {31'b0, busy}, 0);
    check({tag, "_a"},     {24'b0, mult_a}, 0);
    check({tag, "_b"},     {24'b0, mult_b}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    int rs;
    req = '0; a_in = '0; b_in = '0;
    rst_n = 1'b0;
    step(); step();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    step();

    // Single request, 3 * -5
    set_ops(0, 8'd3, 8'hFB);
    expect_rsp(4'b0001, 16'hFFF1, 1'b0);
    req = 4'b0001;
    step();
    check("single_gnt", {28'b0, gnt}, 32'h1);
    check("single_busy", {31'b0, busy}, 1);
    check("single_mult_a", {24'b0, mult_a}, 32'h03);
    check("single_mult_b", {24'b0, mult_b}, 32'hFB);
    g = cyc;
    req = '0;
    drain(40);
    check("single_latency", {31'b0, (last_rsp_cyc - g >= 2) && (last_rsp_cyc - g <= 25)}, 1);
    check("idle_hold_a", {24'b0, mult_a}, 32'h03);
    check("idle_busy", {31'b0, busy}, 0);

    // Corner operands on requester 2
    txn(2, 8'h80, 8'h80, 16'h4000, "corner_gnt0");
    txn(2, 8'h7F, 8'h80, 16'hC080, "corner_gnt1");
    txn(2, 8'h00, 8'hFF, 16'h0000, "corner_gnt2");
    // Requester 3 moves the pointer back to 0
    txn(3, 8'hFF, 8'hFF, 16'h0001, "ptr_wrap_gnt");

    // Round robin with all requesters held
    for (int i = 0; i < NREQ; i++) set_ops(i, 8'(i + 1), 8'(i + 1));
    expect_rsp(4'b0001, 16'd1,  1'b0);
    expect_rsp(4'b0010, 16'd4,  1'b0);
    expect_rsp(4'b0100, 16'd9,  1'b0);
    expect_rsp(4'b1000, 16'd16, 1'b0);
    expect_rsp(4'b0001, 16'd1,  1'b0);
    req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      wait_gnt(NREQ'(1) << (k % NREQ), "rr_gnt");
      if (k > 0) check("rr_gap", cyc - last_rsp_cyc, 1);
      if (k == 4) req = '0;
      step();
    end
    drain(40);

    // Stale first done pulse must be discarded
    mode = 1;
    txn(1, 8'd5, 8'd6, 16'h001E, "stale_gnt");
    mode = 0;

    // Timeout with a dead multiplier
    mode = 2;
    set_ops(2, 8'd1, 8'd1);
    expect_rsp(4'b0100, 16'h0000, 1'b1);
    req = 4'b0100;
    step();
    wait_gnt(4'b0100, "tmo_gnt");
    g = cyc;
    req = '0;
    drain(TIMEOUT + 10);
    check("tmo_latency", last_rsp_cyc - g, TIMEOUT);
    mode = 0;
    txn(0, 8'd4, 8'hFD, 16'hFFF4, "post_tmo_gnt");

    // Reset in the middle of RUN
    set_ops(1, 8'd9, 8'd9);
    req = 4'b0010;
    step();
    wait_gnt(4'b0010, "rst_gnt");
    req = '0;
    for (int i = 0; i < 20 && !mult_done; i++) step();
    check("rst_sync_done", {31'b0, mult_done}, 1);
    step(); step();
    check("rst_run_busy", {31'b0, busy}, 1);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async_rst");
    step();
    rst_n = 1'b1;
    rs = n_rsp;
    repeat (20) step();
    check("no_rsp_after_rst", n_rsp, rs);
    txn(0, 8'd2, 8'd7, 16'h000E, "post_rst_gnt");

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
